// File: rtl/xo_decode_queue.sv
// XO-form decoder for POWER ISA opcode-31 arithmetic instructions, with legality
// checking and a small output FIFO handing decoded entries to dispatch.
module xo_decode_queue #(
    parameter int opcodeWidth      = 6,
    parameter int xOpCodeWidth     = 9,
    parameter int regWidth         = 5,
    parameter int instructionWidth = 32,
    parameter int addrWidth        = 64,
    parameter int fifoDepth        = 4,
    parameter int FXUnitCode       = 0,
    parameter int TrapUnitCode     = 4
) (
    input  logic                          clock_i,
    input  logic                          resetn_i,
    input  logic                          enable_i,
    input  logic [instructionWidth-1:0]   instruction_i,
    input  logic [addrWidth-1:0]          pc_i,
    input  logic                          mode64_i,
    input  logic                          flush_i,
    input  logic                          ready_i,
    output logic                          stall_o,
    output logic                          enable_o,
    output logic [regWidth-1:0]           reg1_o,
    output logic [regWidth-1:0]           reg2_o,
    output logic [regWidth-1:0]           reg3_o,
    output logic [xOpCodeWidth-1:0]       xOpCode_o,
    output logic                          bit1_o,
    output logic                          bit2_o,
    output logic [2:0]                    functionalUnitCode_o,
    output logic                          illegal_o,
    output logic [addrWidth-1:0]          pc_o,
    output logic [$clog2(fifoDepth):0]    count_o
);

    localparam int PTR_W = $clog2(fifoDepth);
    localparam int CNT_W = PTR_W + 1;

    // Instruction fields use big-endian numbering: ISA bit k is vector bit (W-1-k).
    localparam int OP_MSB = instructionWidth - 1;
    localparam int RT_MSB = OP_MSB - opcodeWidth;
    localparam int RA_MSB = RT_MSB - regWidth;
    localparam int RB_MSB = RA_MSB - regWidth;
    localparam int OE_POS = RB_MSB - regWidth;
    localparam int XO_MSB = OE_POS - 1;

    localparam logic [opcodeWidth-1:0] OPCODE_XO = opcodeWidth'(6'd31);
    localparam logic [2:0]             FX_CODE   = 3'(FXUnitCode);
    localparam logic [2:0]             TRAP_CODE = 3'(TrapUnitCode);
    localparam logic [CNT_W-1:0]       DEPTH_C   = CNT_W'(fifoDepth);

    typedef struct packed {
        logic [regWidth-1:0]     rt;
        logic [regWidth-1:0]     ra;
        logic [regWidth-1:0]     rb;
        logic [xOpCodeWidth-1:0] xop;
        logic                    oe;
        logic                    rc;
        logic [2:0]              fu;
        logic                    illegal;
        logic [addrWidth-1:0]    pc;
    } entry_t;

    function automatic logic is_supported(input logic [xOpCodeWidth-1:0] xop);
        case (xop)
            9'd266, 9'd40,  9'd10,  9'd8,   9'd138, 9'd136, 9'd234,
            9'd232, 9'd200, 9'd202, 9'd104, 9'd235, 9'd75,  9'd11,
            9'd491, 9'd459, 9'd427, 9'd395, 9'd233, 9'd73,  9'd9,
            9'd489, 9'd457, 9'd425, 9'd393, 9'd74:  is_supported = 1'b1;
            default:                                is_supported = 1'b0;
        endcase
    endfunction

    // Doubleword multiply/divide forms, only legal in 64-bit mode.
    function automatic logic is_dword_op(input logic [xOpCodeWidth-1:0] xop);
        case (xop)
            9'd233, 9'd73, 9'd9, 9'd489, 9'd457, 9'd425, 9'd393: is_dword_op = 1'b1;
            default:                                             is_dword_op = 1'b0;
        endcase
    endfunction

    // Forms whose bit 21 is reserved rather than an OE flag.
    function automatic logic is_oe_reserved(input logic [xOpCodeWidth-1:0] xop);
        case (xop)
            9'd75, 9'd11, 9'd73, 9'd9, 9'd74: is_oe_reserved = 1'b1;
            default:                          is_oe_reserved = 1'b0;
        endcase
    endfunction

    entry_t                mem_r [fifoDepth];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    entry_t                entry_s;
    entry_t                head_s;
    logic                  full_s;
    logic                  nonempty_s;
    logic                  accept_s;
    logic                  decodable_s;
    logic                  push_s;
    logic                  pop_s;

    assign full_s     = (count_r == DEPTH_C);
    assign nonempty_s = (count_r != {CNT_W{1'b0}});

    // Decode the incoming instruction into a candidate queue entry.
    always_comb begin
        entry_s         = '0;
        entry_s.rt      = instruction_i[RT_MSB -: regWidth];
        entry_s.ra      = instruction_i[RA_MSB -: regWidth];
        entry_s.rb      = instruction_i[RB_MSB -: regWidth];
        entry_s.oe      = instruction_i[OE_POS];
        entry_s.xop     = instruction_i[XO_MSB -: xOpCodeWidth];
        entry_s.rc      = instruction_i[0];
        entry_s.pc      = pc_i;
        entry_s.illegal = (!mode64_i && is_dword_op(entry_s.xop)) ||
                          (entry_s.oe && is_oe_reserved(entry_s.xop));
        entry_s.fu      = entry_s.illegal ? TRAP_CODE : FX_CODE;
        decodable_s     = (instruction_i[OP_MSB -: opcodeWidth] == OPCODE_XO) &&
                          is_supported(entry_s.xop);
    end

    // Handshake qualification; flush suppresses both push and pop.
    always_comb begin
        accept_s = enable_i && !full_s && !flush_i;
        push_s   = accept_s && decodable_s;
        pop_s    = nonempty_s && ready_i && !flush_i;
    end

    // Entry storage, cleared on reset so idle outputs read as zero.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < fifoDepth; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s               = mem_r[rd_ptr_r];
    assign stall_o              = full_s;
    assign enable_o             = nonempty_s;
    assign count_o              = count_r;
    assign reg1_o               = head_s.rt;
    assign reg2_o               = head_s.ra;
    assign reg3_o               = head_s.rb;
    assign xOpCode_o            = head_s.xop;
    assign bit1_o               = head_s.oe;
    assign bit2_o               = head_s.rc;
    assign functionalUnitCode_o = head_s.fu;
    assign illegal_o            = head_s.illegal;
    assign pc_o                 = head_s.pc;

endmodule

// File: tb/tb_xo_decode_queue.sv
// Scoreboard bench for xo_decode_queue: a reference model predicts each entry
// when it is accepted and the head is compared whenever dispatch takes it.
module tb_xo_decode_queue;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic        enable_i;
    logic [31:0] instruction_i;
    logic [63:0] pc_i;
    logic        mode64_i;
    logic        flush_i;
    logic        ready_i;
    logic        stall_o;
    logic        enable_o;
    logic [4:0]  reg1_o, reg2_o, reg3_o;
    logic [8:0]  xOpCode_o;
    logic        bit1_o, bit2_o;
    logic [2:0]  functionalUnitCode_o;
    logic        illegal_o;
    logic [63:0] pc_o;
    logic [2:0]  count_o;

    xo_decode_queue dut (
        .clock_i(clock_i), .resetn_i(resetn_i), .enable_i(enable_i),
        .instruction_i(instruction_i), .pc_i(pc_i), .mode64_i(mode64_i),
        .flush_i(flush_i), .ready_i(ready_i), .stall_o(stall_o),
        .enable_o(enable_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .xOpCode_o(xOpCode_o), .bit1_o(bit1_o), .bit2_o(bit2_o),
        .functionalUnitCode_o(functionalUnitCode_o), .illegal_o(illegal_o),
        .pc_o(pc_o), .count_o(count_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [4:0]  rt, ra, rb;
        logic [8:0]  xop;
        logic        oe, rc;
        logic [2:0]  fu;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   model_count;
    int   check_count = 0;
    int   pass_count  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs === exp) pass_count++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit in_list(input int v, input int lst[$]);
        foreach (lst[i]) if (lst[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pushes(input logic [31:0] ins);
        int supported[$] = '{266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104, 235, 75,
                             11, 491, 459, 427, 395, 233, 73, 9, 489, 457, 425, 393, 74};
        return (ins[31:26] == 6'd31) && in_list(int'(ins[9:1]), supported);
    endfunction

    function automatic exp_t exp_of(input logic [31:0] ins, input logic [63:0] pc, input logic m64);
        int dword[$] = '{233, 73, 9, 489, 457, 425, 393};
        int resv[$]  = '{75, 11, 73, 9, 74};
        exp_t e;
        e.rt  = ins[25:21];
        e.ra  = ins[20:16];
        e.rb  = ins[15:11];
        e.oe  = ins[10];
        e.xop = ins[9:1];
        e.rc  = ins[0];
        e.pc  = pc;
        e.ill = (!m64 && in_list(int'(e.xop), dword)) || (e.oe && in_list(int'(e.xop), resv));
        e.fu  = e.ill ? 3'd4 : 3'd0;
        return e;
    endfunction

    logic model_acc, model_pop;
    assign model_acc = enable_i && (model_count != 4) && !flush_i && pushes(instruction_i);
    assign model_pop = (model_count != 0) && ready_i && !flush_i;

    // Reference occupancy and scoreboard push at each accepting edge.
    always @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            model_count <= 0;
            sb.delete();
        end else if (flush_i) begin
            model_count <= 0;
            sb.delete();
        end else begin
            if (model_acc) sb.push_back(exp_of(instruction_i, pc_i, mode64_i));
            model_count <= model_count + int'(model_acc) - int'(model_pop);
        end
    end

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check_val("reg1", reg1_o, e.rt);
        check_val("reg2", reg2_o, e.ra);
        check_val("reg3", reg3_o, e.rb);
        check_val("xop", xOpCode_o, e.xop);
        check_val("oe", bit1_o, e.oe);
        check_val("rc", bit2_o, e.rc);
        check_val("unit", functionalUnitCode_o, e.fu);
        check_val("illegal", illegal_o, e.ill);
        check_val("pc", pc_o, e.pc);
    endtask

    // Mid-cycle monitor: status against the model, head against the scoreboard.
    always @(negedge clock_i) begin
        if (resetn_i) begin
            check_val("count_mon", count_o, 64'(model_count));
            check_val("enable_mon", enable_o, 64'(model_count != 0));
            check_val("stall_mon", stall_o, 64'(model_count == 4));
            if ((model_count != 0) && ready_i && !flush_i) compare_head();
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic m64);
        enable_i      = 1'b1;
        instruction_i = ins;
        pc_i          = pc;
        mode64_i      = m64;
    endtask

    task automatic idle();
        enable_i = 1'b0;
    endtask

    task automatic drain();
        ready_i = 1'b1;
        idle();
        for (int i = 0; i < 20 && count_o != 3'd0; i++) tick();
        check_val("drain_empty", count_o, 64'd0);
    endtask

    localparam logic [31:0] ADD   = 32'h7C642A14;
    localparam logic [31:0] MULLD = 32'h7C2219D2;
    localparam logic [31:0] MULHW = 32'h7C221C96;
    localparam logic [31:0] ADDI  = 32'h38600001;
    localparam logic [31:0] SYNC  = 32'h7C0004AC;
    localparam logic [31:0] DIVD  = 32'h7C6423D2;
    localparam logic [31:0] ADDO  = 32'h7C642E14;
    localparam logic [31:0] SUBFR = 32'h7C642851;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tbl [8];
        tbl = '{ADD, MULLD, MULHW, ADDI, SYNC, DIVD, ADDO, SUBFR};
        resetn_i = 1'b0; enable_i = 1'b0; instruction_i = '0; pc_i = '0;
        mode64_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
        #1;
        check_val("rst_count", count_o, 64'd0);
        check_val("rst_enable", enable_o, 64'd0);
        check_val("rst_stall", stall_o, 64'd0);
        check_val("rst_reg1", reg1_o, 64'd0);
        check_val("rst_pc", pc_o, 64'd0);
        repeat (2) @(posedge clock_i);
        #1 resetn_i = 1'b1;

        // add r3,r4,r5 visible the cycle after acceptance, gone the cycle after.
        drive(ADD, 64'h100, 1'b1);
        tick();
        idle();
        check_val("add_enable", enable_o, 64'd1);
        check_val("add_rt", reg1_o, 64'd3);
        check_val("add_ra", reg2_o, 64'd4);
        check_val("add_rb", reg3_o, 64'd5);
        check_val("add_xop", xOpCode_o, 64'd266);
        check_val("add_oe", bit1_o, 64'd0);
        check_val("add_rc", bit2_o, 64'd0);
        check_val("add_unit", functionalUnitCode_o, 64'd0);
        check_val("add_illegal", illegal_o, 64'd0);
        check_val("add_pc", pc_o, 64'h100);
        tick();
        check_val("add_gone", enable_o, 64'd0);

        // mulld: illegal in 32-bit mode, legal in 64-bit mode.
        drive(MULLD, 64'h104, 1'b0);
        tick(); idle();
        check_val("mulld32_illegal", illegal_o, 64'd1);
        check_val("mulld32_unit", functionalUnitCode_o, 64'd4);
        tick();
        drive(MULLD, 64'h108, 1'b1);
        tick(); idle();
        check_val("mulld64_illegal", illegal_o, 64'd0);
        check_val("mulld64_unit", functionalUnitCode_o, 64'd0);
        tick();

        // mulhw with reserved bit 21 set; then non-31 and unsupported xop dropped.
        drive(MULHW, 64'h10C, 1'b1);
        tick(); idle();
        check_val("mulhw_illegal", illegal_o, 64'd1);
        check_val("mulhw_unit", functionalUnitCode_o, 64'd4);
        tick();
        drive(ADDI, 64'h110, 1'b1);
        tick(); idle();
        check_val("addi_dropped", count_o, 64'd0);
        drive(SYNC, 64'h114, 1'b1);
        tick(); idle();
        check_val("sync_dropped", count_o, 64'd0);

        // Fill to full with dispatch blocked, then release; pointers wrap.
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ADD | (32'(i + 1) << 21), 64'h200 + 64'(4 * i), 1'b1);
            tick();
        end
        check_val("full_count", count_o, 64'd4);
        check_val("full_stall", stall_o, 64'd1);
        drive(ADD | (32'd9 << 21), 64'h210, 1'b1);
        tick();
        check_val("held_count", count_o, 64'd4);
        check_val("held_stall", stall_o, 64'd1);
        check_val("held_pc", pc_o, 64'h200);
        ready_i = 1'b1;
        tick();
        check_val("pop_only_count", count_o, 64'd3);
        check_val("pop_only_stall", stall_o, 64'd0);
        tick();
        check_val("fifth_in_count", count_o, 64'd3);
        drain();

        // Two queued, simultaneous push/pop, then flush beats a push.
        ready_i = 1'b0;
        drive(SUBFR, 64'h300, 1'b1); tick();
        drive(DIVD, 64'h304, 1'b0);  tick();
        idle();
        check_val("two_count", count_o, 64'd2);
        ready_i = 1'b1;
        drive(ADDO, 64'h308, 1'b1);
        tick();
        check_val("pushpop_count", count_o, 64'd2);
        check_val("pushpop_head_pc", pc_o, 64'h304);
        ready_i = 1'b0;
        flush_i = 1'b1;
        drive(ADD, 64'h30C, 1'b1);
        tick();
        flush_i = 1'b0;
        idle();
        check_val("flush_count", count_o, 64'd0);
        check_val("flush_enable", enable_o, 64'd0);

        // Randomised traffic through the scoreboard.
        for (int i = 0; i < 60; i++) begin
            enable_i      = ($urandom_range(9) < 7);
            instruction_i = tbl[$urandom_range(7)];
            pc_i          = {$urandom, $urandom};
            mode64_i      = $urandom_range(1);
            ready_i       = ($urandom_range(9) < 6);
            flush_i       = ($urandom_range(19) == 0);
            tick();
        end
        flush_i = 1'b0;
        drain();

        // Asynchronous reset between edges with three entries queued.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(ADD, 64'h400 + 64'(4 * i), 1'b1);
            tick();
        end
        idle();
        check_val("pre_reset_count", count_o, 64'd3);
        #1 resetn_i = 1'b0;
        #1;
        check_val("async_rst_enable", enable_o, 64'd0);
        check_val("async_rst_count", count_o, 64'd0);
        check_val("async_rst_pc", pc_o, 64'd0);
        #1 resetn_i = 1'b1;
        tick();
        check_val("post_reset_count", count_o, 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
